// File: rtl/sfix2float.sv
// Signed Q1.FRACTIONAL_BITS fixed-point to IEEE-754 single conversion, multi-cycle
// custom-instruction slave with a one-bit-per-cycle normalising shifter.
module sfix2float #(
  parameter int FRACTIONAL_BITS = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int W  = FRACTIONAL_BITS + 2;
  localparam int MB = W - 1;
  localparam int CW = $clog2(W);
  // Exponent when mag[W-1] is already set (count == 0).
  localparam logic [7:0] EXP_BASE = 8'(127 + W - 1 - FRACTIONAL_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_PACK
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mag_q, mag_d;
  logic [CW-1:0]   count_q, count_d;
  logic            sign_q, sign_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;
  logic [31:0]     result_q, result_d;

  logic [W-1:0]    fixed_in;
  logic [W-1:0]    abs_in;
  logic [7:0]      exp_w;
  logic [22:0]     mant_w;

  assign fixed_in = dataa[W-1:0];
  // The most negative input maps to 2^(W-1), which still fits W unsigned bits.
  assign abs_in   = fixed_in[W-1] ? (~fixed_in + {{(W-1){1'b0}}, 1'b1}) : fixed_in;
  assign exp_w    = EXP_BASE - {{(8-CW){1'b0}}, count_q};

  generate
    if (MB >= 23) begin : g_mant_trunc
      assign mant_w = mag_q[W-2 -: 23];
    end else begin : g_mant_pad
      assign mant_w = {mag_q[W-2:0], {(23-MB){1'b0}}};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    count_d  = count_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    done_d   = done_q;
    result_d = result_q;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          done_d = 1'b0;
          // A start seen during the done cycle waits for the next IDLE cycle.
          if (start && !done_q) begin
            sign_d  = fixed_in[W-1];
            mag_d   = abs_in;
            count_d = '0;
            zero_d  = 1'b0;
            state_d = S_NORM;
          end
        end
        S_NORM: begin
          if (mag_q == '0) begin
            zero_d  = 1'b1;
            state_d = S_PACK;
          end else if (mag_q[W-1]) begin
            state_d = S_PACK;
          end else begin
            mag_d   = {mag_q[W-2:0], 1'b0};
            count_d = count_q + 1'b1;
          end
        end
        S_PACK: begin
          result_d = zero_q ? 32'h0000_0000 : {sign_q, exp_w, mant_w};
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      count_q  <= count_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_sfix2float.sv
// Directed bench for sfix2float (FRACTIONAL_BITS=22): conversion values, latency,
// stall, ignored starts and reset abort.
module tb_sfix2float;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  sfix2float #(.FRACTIONAL_BITS(22)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue one conversion and follow it to done.
  // stall_at: cycle after which clk_en is held low for 5 edges (-1 = none).
  // ign_at:   cycle at which a stray one-cycle start is pulsed while busy (-1 = none).
  // hold:     keep clk_en low for 3 cycles while done is high.
  task automatic run(input string tag, input logic [31:0] d, input logic [31:0] exp_r,
                     input int exp_lat, input int stall_at, input int ign_at, input bit hold);
    int cyc;
    int lat;
    lat = -1;
    cyc = 0;
    @(negedge clk);
    dataa = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dataa = 32'hDEAD_BEEF;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (lat < 0 && cyc < 60) begin
      if (cyc == stall_at) clk_en = 1'b0;
      if (cyc == stall_at + 5) clk_en = 1'b1;
      if (cyc == ign_at) begin
        start = 1'b1;
        dataa = 32'h0040_0000;
      end
      if (cyc == ign_at + 1) begin
        start = 1'b0;
        dataa = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) lat = cyc;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp_r);
    $display("conv %-10s dataa=%h result=%h latency=%0d", tag, d, result, lat);
    if (hold) begin
      clk_en = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1;
        chk({tag, " done held"}, 32'(done), 32'd1);
        chk({tag, " result held"}, result, exp_r);
      end
      clk_en = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " idle after"}, 32'(busy), 32'd0);
    chk({tag, " result keep"}, result, exp_r);
  endtask

  initial begin
    int seen_done;
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'h0);
    reset = 1'b0;

    run("plus1",   32'h0040_0000, 32'h3F80_0000, 3,  -1, -1, 1'b1);
    run("minus1",  32'h00C0_0000, 32'hBF80_0000, 3,  -1, -1, 1'b0);
    run("minus2",  32'h0080_0000, 32'hC000_0000, 2,  -1, -1, 1'b0);
    run("pi4",     32'h0032_43F7, 32'h3F49_0FDC, 4,  -1, -1, 1'b0);
    run("pi4_up",  32'hFF32_43F7, 32'h3F49_0FDC, 4,  -1, -1, 1'b0);
    run("maxpos",  32'h007F_FFFF, 32'h3FFF_FFFE, 3,  -1, -1, 1'b0);
    run("zero",    32'h0000_0000, 32'h0000_0000, 2,  -1, -1, 1'b0);
    run("lsb",     32'h0000_0001, 32'h3480_0000, 25, -1, 5,  1'b0);
    run("neg_lsb", 32'h00FF_FFFF, 32'hB480_0000, 25, -1, -1, 1'b0);
    run("stall",   32'h0032_43F7, 32'h3F49_0FDC, 9,  1,  3,  1'b0);

    // Reset in the middle of a long normalisation.
    @(negedge clk);
    dataa = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort busy before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", result, 32'h0);
    seen_done = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    chk("abort no done", 32'(seen_done), 32'd0);
    $display("conv abort      reset mid-NORM, done pulses seen=%0d", seen_done);

    run("after_rst", 32'h0040_0000, 32'h3F80_0000, 3, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
